// File: rtl/result_buffer.sv
// Candidate-result buffer: stores detected windows {x, y, scale mask} in a circular
// array and drains a snapshot of them as an x, y, candidate word stream on request.
module result_buffer #(
  parameter int DATA_WIDTH = 12,
  parameter int NUM_RESIZE = 5,
  parameter int DEPTH      = 64,
  parameter int ADDR_WIDTH = 6
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  clear,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [DATA_WIDTH-1:0] ori_x,
  input  logic [DATA_WIDTH-1:0] ori_y,
  input  logic [NUM_RESIZE-1:0] candidate,
  input  logic                  read_start,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [DATA_WIDTH-1:0] out_data,
  output logic                  read_done,
  output logic [ADDR_WIDTH:0]   count,
  output logic                  overflow
);

  typedef enum logic [2:0] {IDLE, SEND_X, SEND_Y, SEND_C, DONE} state_t;

  localparam logic [ADDR_WIDTH:0]   FULL_COUNT = (ADDR_WIDTH + 1)'(DEPTH);
  localparam logic [ADDR_WIDTH:0]   ONE_COUNT  = (ADDR_WIDTH + 1)'(1);
  localparam logic [ADDR_WIDTH-1:0] ONE_PTR    = ADDR_WIDTH'(1);

  state_t state, state_next;

  logic [DATA_WIDTH-1:0] mem_x [DEPTH];
  logic [DATA_WIDTH-1:0] mem_y [DEPTH];
  logic [NUM_RESIZE-1:0] mem_c [DEPTH];

  logic [ADDR_WIDTH-1:0] wr_ptr, rd_ptr;
  logic [ADDR_WIDTH:0]   remaining;
  logic                  full, has_cand, push, lost, pop, start;

  // Fullness uses the pre-pop count, so a pop never makes room for a same-cycle write.
  assign full      = (count == FULL_COUNT);
  assign has_cand  = |candidate;
  assign push      = in_valid && has_cand && !full;
  assign lost      = in_valid && has_cand && full;
  assign pop       = (state == SEND_C) && out_ready;
  assign start     = (state == IDLE) && read_start;
  assign in_ready  = !full;
  assign out_valid = (state == SEND_X) || (state == SEND_Y) || (state == SEND_C);
  assign read_done = (state == DONE);

  always_comb begin
    state_next = state;
    unique case (state)
      IDLE:    if (read_start) state_next = (count != '0) ? SEND_X : DONE;
      SEND_X:  if (out_ready) state_next = SEND_Y;
      SEND_Y:  if (out_ready) state_next = SEND_C;
      SEND_C:  if (out_ready) state_next = (remaining > ONE_COUNT) ? SEND_X : DONE;
      DONE:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_comb begin
    out_data = '0;
    unique case (state)
      SEND_X:  out_data = mem_x[rd_ptr];
      SEND_Y:  out_data = mem_y[rd_ptr];
      SEND_C:  out_data = DATA_WIDTH'(mem_c[rd_ptr]);
      default: out_data = '0;
    endcase
  end

  // remaining is a snapshot of count at read_start, so later writes stay out of this drain.
  always_ff @(posedge clk) begin
    if (reset || clear) begin
      state     <= IDLE;
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      count     <= '0;
      remaining <= '0;
      overflow  <= 1'b0;
    end else begin
      state <= state_next;
      if (push) wr_ptr <= wr_ptr + ONE_PTR;
      if (pop) rd_ptr <= rd_ptr + ONE_PTR;
      unique case ({push, pop})
        2'b10:   count <= count + ONE_COUNT;
        2'b01:   count <= count - ONE_COUNT;
        default: count <= count;
      endcase
      if (lost) overflow <= 1'b1;
      if (start) remaining <= count;
      else if (pop) remaining <= remaining - ONE_COUNT;
    end
  end

  // Record storage carries no reset; contents are only observed through valid pointers.
  always_ff @(posedge clk) begin
    if (!reset && !clear && push) begin
      mem_x[wr_ptr] <= ori_x;
      mem_y[wr_ptr] <= ori_y;
      mem_c[wr_ptr] <= candidate;
    end
  end

endmodule

// File: tb/tb_result_buffer.sv
// Directed self-checking bench for result_buffer: ordering, full/overflow, stalls,
// writes during drain with pointer wrap, empty drain, and clear/reset aborts.
module tb_result_buffer;

  logic        clk = 1'b0;
  logic        reset, clear, in_valid, in_ready, read_start;
  logic        out_valid, out_ready, read_done, overflow;
  logic [11:0] ori_x, ori_y, out_data;
  logic [4:0]  candidate;
  logic [6:0]  count;

  int total = 0;
  int bad   = 0;
  int exp_q[$];
  int wr_q[$];

  result_buffer #(.DATA_WIDTH(12), .NUM_RESIZE(5), .DEPTH(64), .ADDR_WIDTH(6)) dut (
    .clk(clk), .reset(reset), .clear(clear), .in_valid(in_valid), .in_ready(in_ready),
    .ori_x(ori_x), .ori_y(ori_y), .candidate(candidate), .read_start(read_start),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .read_done(read_done), .count(count), .overflow(overflow)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    total++;
    assert (observed === expected)
    else begin
      bad++;
      $error("[TB] FAIL %s observed=%0d expected=%0d", tag, observed, expected);
    end
  endtask

  task automatic applyStimulus(input int x, input int y, input int c);
    in_valid  = 1'b1;
    ori_x     = 12'(x);
    ori_y     = 12'(y);
    candidate = 5'(c);
    step();
    in_valid  = 1'b0;
  endtask

  // Starts a drain with out_ready held high; every cycle before read_done must carry
  // the next word of exp_q. wr_q triples are driven as writes, one per drain cycle.
  task automatic drain_check(input string tag);
    int  words;
    int  n;
    bit  done_seen;
    words = 0;
    n = 0;
    done_seen = 1'b0;
    out_ready = 1'b1;
    read_start = 1'b1;
    step();
    read_start = 1'b0;
    while (!done_seen && n < 400) begin
      if (read_done) begin
        done_seen = 1'b1;
        checkOutput({tag, "_valid_at_done"}, 32'(out_valid), 0);
      end else begin
        checkOutput({tag, "_no_bubble"}, 32'(out_valid), 1);
        if (out_valid) begin
          if (words < exp_q.size()) checkOutput({tag, "_data"}, 32'(out_data), 32'(exp_q[words]));
          words++;
        end
        if (wr_q.size() >= 3) begin
          in_valid  = 1'b1;
          ori_x     = 12'(wr_q.pop_front());
          ori_y     = 12'(wr_q.pop_front());
          candidate = 5'(wr_q.pop_front());
        end else begin
          in_valid = 1'b0;
        end
        step();
        n++;
      end
    end
    in_valid = 1'b0;
    checkOutput({tag, "_words"}, 32'(words), 32'(exp_q.size()));
    checkOutput({tag, "_done_seen"}, 32'(done_seen), 1);
    exp_q.delete();
    wr_q.delete();
    step();
  endtask

  initial begin
    int         w;
    logic [3:0] pat;
    int         stall_exp[6];

    reset = 1'b1; clear = 1'b0; in_valid = 1'b0; read_start = 1'b0; out_ready = 1'b0;
    ori_x = '0; ori_y = '0; candidate = '0;
    step();
    step();
    reset = 1'b0;
    $display("[TB] reset values");
    checkOutput("rst_in_ready", 32'(in_ready), 1);
    checkOutput("rst_out_valid", 32'(out_valid), 0);
    checkOutput("rst_out_data", 32'(out_data), 0);
    checkOutput("rst_read_done", 32'(read_done), 0);
    checkOutput("rst_count", 32'(count), 0);
    checkOutput("rst_overflow", 32'(overflow), 0);

    $display("[TB] basic ordering and zero-candidate drop");
    applyStimulus(10, 20, 1);
    applyStimulus(30, 40, 0);
    applyStimulus(50, 60, 18);
    checkOutput("basic_count", 32'(count), 2);
    exp_q = '{10, 20, 1, 50, 60, 18};
    drain_check("basic");
    checkOutput("basic_count_after", 32'(count), 0);

    $display("[TB] fill to capacity and overflow");
    for (int i = 0; i < 64; i++) applyStimulus(100 + i, 200 + i, (i % 31) + 1);
    checkOutput("full_in_ready", 32'(in_ready), 0);
    checkOutput("full_count", 32'(count), 64);
    checkOutput("full_overflow_before", 32'(overflow), 0);
    applyStimulus(999, 999, 1);
    checkOutput("full_overflow", 32'(overflow), 1);
    checkOutput("full_count_after_lost", 32'(count), 64);
    for (int i = 0; i < 64; i++) begin
      exp_q.push_back(100 + i);
      exp_q.push_back(200 + i);
      exp_q.push_back((i % 31) + 1);
    end
    // Write lands on the first SEND_C cycle while still full: must be lost.
    wr_q = '{0, 0, 0, 0, 0, 0, 77, 77, 1};
    drain_check("full");
    checkOutput("full_count_after_drain", 32'(count), 0);
    checkOutput("full_overflow_kept", 32'(overflow), 1);
    clear = 1'b1;
    step();
    clear = 1'b0;
    checkOutput("clear_overflow", 32'(overflow), 0);
    checkOutput("clear_in_ready", 32'(in_ready), 1);

    $display("[TB] back-pressured drain");
    applyStimulus(7, 8, 3);
    applyStimulus(9, 10, 4);
    stall_exp = '{7, 8, 3, 9, 10, 4};
    pat = 4'b1001;
    read_start = 1'b1;
    step();
    read_start = 1'b0;
    w = 0;
    for (int n = 0; n < 40 && w < 6; n++) begin
      out_ready = pat[n % 4];
      checkOutput("stall_valid", 32'(out_valid), 1);
      checkOutput("stall_data", 32'(out_data), 32'(stall_exp[w]));
      step();
      if (out_ready) w++;
    end
    checkOutput("stall_words", 32'(w), 6);
    checkOutput("stall_read_done", 32'(read_done), 1);
    checkOutput("stall_valid_end", 32'(out_valid), 0);
    out_ready = 1'b1;
    step();

    $display("[TB] pointer wrap and writes during drain");
    for (int i = 0; i < 61; i++) begin
      applyStimulus(i + 1, i + 2, 1);
      exp_q.push_back(i + 1);
      exp_q.push_back(i + 2);
      exp_q.push_back(1);
    end
    drain_check("advance");
    applyStimulus(1, 2, 1);
    applyStimulus(3, 4, 2);
    checkOutput("wrap_count", 32'(count), 2);
    exp_q = '{1, 2, 1, 3, 4, 2};
    wr_q  = '{5, 6, 4, 7, 8, 8};
    drain_check("wrap");
    checkOutput("wrap_count_new", 32'(count), 2);
    exp_q = '{5, 6, 4, 7, 8, 8};
    drain_check("wrap_new");
    checkOutput("wrap_count_final", 32'(count), 0);

    $display("[TB] empty drain");
    read_start = 1'b1;
    step();
    read_start = 1'b0;
    checkOutput("empty_read_done", 32'(read_done), 1);
    checkOutput("empty_valid", 32'(out_valid), 0);
    step();
    checkOutput("empty_read_done_off", 32'(read_done), 0);
    checkOutput("empty_valid_after", 32'(out_valid), 0);

    $display("[TB] clear mid-drain");
    applyStimulus(11, 12, 1);
    read_start = 1'b1;
    step();
    read_start = 1'b0;
    step();
    checkOutput("clr_in_send_y", 32'(out_data), 12);
    clear = 1'b1;
    out_ready = 1'b0;
    step();
    clear = 1'b0;
    out_ready = 1'b1;
    checkOutput("clr_valid", 32'(out_valid), 0);
    checkOutput("clr_count", 32'(count), 0);
    checkOutput("clr_read_done", 32'(read_done), 0);
    step();
    checkOutput("clr_read_done_next", 32'(read_done), 0);
    applyStimulus(13, 14, 2);
    exp_q = '{13, 14, 2};
    drain_check("clr_after");

    $display("[TB] reset mid-drain");
    applyStimulus(21, 22, 3);
    read_start = 1'b1;
    step();
    read_start = 1'b0;
    step();
    checkOutput("rst_in_send_y", 32'(out_data), 22);
    reset = 1'b1;
    out_ready = 1'b0;
    step();
    reset = 1'b0;
    out_ready = 1'b1;
    checkOutput("rstd_valid", 32'(out_valid), 0);
    checkOutput("rstd_count", 32'(count), 0);
    checkOutput("rstd_read_done", 32'(read_done), 0);
    step();
    checkOutput("rstd_read_done_next", 32'(read_done), 0);
    applyStimulus(23, 24, 16);
    exp_q = '{23, 24, 16};
    drain_check("rst_after");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/result_buffer.md
# result_buffer

Parametrised candidate-result buffer for the face detection system. It sits after the multi-scale classifier stage. It stores detected windows as records of origin x, origin y and a per-scale candidate mask, and drops records that carry no candidate. On request it drains a snapshot of the stored records as a three-word-per-record stream with a valid/ready handshake. It adds depth/width parametrisation, whole-record single-cycle writes, overflow reporting, clear and back-pressured readout.

## Interface
- DATA_WIDTH, 12, width of ori_x, ori_y and out_data words
- NUM_RESIZE, 5, number of resize scales = candidate mask width; must be <= DATA_WIDTH
- DEPTH, 64, record capacity; power of two
- ADDR_WIDTH, 6, log2(DEPTH)

- clk  in  1  single clock; all logic on rising edge
- reset  in  1  synchronous, active-high
- clear  in  1  synchronous flush of contents and readout
- in_valid  in  1  record present on ori_x/ori_y/candidate
- in_ready  out  1  buffer not full
- ori_x  in  DATA_WIDTH  window origin x
- ori_y  in  DATA_WIDTH  window origin y
- candidate  in  NUM_RESIZE  bit i = detection at scale i
- read_start  in  1  pulse: begin drain of current contents
- out_valid  out  1  out_data holds a valid word
- out_ready  in  1  consumer accepts word
- out_data  out  DATA_WIDTH  x, y, then zero-extended candidate
- read_done  out  1  one-cycle pulse: drain finished
- count  out  ADDR_WIDTH+1  stored records, 0..DEPTH
- overflow  out  1  sticky: a record was lost to full buffer

## Operation
- Storage: circular register array of DEPTH records, each {x, y, candidate}. wr_ptr and rd_ptr are ADDR_WIDTH bits and wrap at DEPTH. count tracks occupancy.
- Write: in_valid=1 and candidate!=0 and count<DEPTH: store at wr_ptr, then wr_ptr+1.
- Write with candidate==0: discarded silently; overflow unaffected.
- Write with candidate!=0 and count==DEPTH: discarded; overflow<=1.
- in_ready = (count<DEPTH). It is advisory; the producer need not stall.
- Readout FSM states: IDLE, SEND_X, SEND_Y, SEND_C, DONE.
- IDLE + read_start:
  - Latch remaining = count.
  - If count>0, go to SEND_X; otherwise go to DONE.
  - read_start is ignored outside IDLE.
- Each word transfers when out_valid && out_ready.
  - SEND_X goes to SEND_Y.
  - SEND_Y goes to SEND_C.
  - SEND_C pops the head record (rd_ptr+1, remaining-1), then goes to SEND_X if remaining>1, otherwise to DONE.
- DONE: read_done=1 for one cycle, then IDLE.
- out_valid=1 exactly in SEND_X/Y/C. out_data is taken from the head record field selected by state; the candidate is zero-extended.
- Writes continue during readout. Records written after read_start are not part of that drain.
- clear: resets pointers, count and FSM to IDLE, and sets overflow to 0. No read_done is issued for an aborted drain. A write in the same cycle as clear is discarded.

## Timing
- Reset values:
  - in_ready=1
  - out_valid=0
  - out_data=0
  - read_done=0
  - count=0
  - overflow=0
  - FSM=IDLE
  - pointers=0
- Write latency: record accepted at edge t is visible in count after t and is readable by a read_start in cycle t+1.
- Same-cycle push and pop: both take effect and count is unchanged. When full, a pop does not free space for a write in the same cycle; that write is an overflow.
- read_start sampled at edge t with count>0: out_valid=1 with x of the oldest record from t+1.
- No bubbles: the word after one transferred at edge c is valid from c+1.
- While out_valid && !out_ready, out_data and state hold.
- Last C word transferred at edge c: read_done=1 during cycle c+1, and out_valid=0 from c+1.
- read_start with count==0: read_done=1 in the cycle after, with no out_valid.
- reset and clear take effect at the sampling edge. reset has priority over clear, which has priority over all other actions.

## Test plan
- Write 3 records (10,20,5'b00001), (30,40,5'b00000), (50,60,5'b10010), then read_start with out_ready=1.
  - Required: count=2.
  - Stream is 10,20,1,50,60,18 on consecutive cycles.
  - read_done in the cycle after 18.
  - count=0.
- Fill DEPTH=64 records, then write one more nonzero record.
  - Required: in_ready=0 and count=64.
  - overflow=1.
  - Drain returns the first 64 records in order.
  - clear sets overflow to 0.
- Drain with out_ready toggling 1,0,0,1 repeatedly.
  - Required: out_data stable while stalled.
  - No word duplicated or skipped.
- Write new records during an active drain of 2 records.
  - Required: exactly 6 words are emitted.
  - The new records remain afterwards (count equals the new writes).
  - Pointer wrap past 63 is exercised.
- read_start on an empty buffer.
  - Required: read_done pulse one cycle later, out_valid never 1.
- Assert clear, and separately reset, mid-drain in SEND_Y.
  - Required: next cycle out_valid=0, count=0, no read_done.
  - A subsequent write plus read_start works normally.
